// File: rtl/mult_div_pkg.sv
// Shared encodings for the MULT/DIV sequencer: FSM states, operation select and iteration count.
package mult_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  // One iteration per operand bit; also the default operand width.
  localparam int MD_ITERS = 32;

endpackage

// File: rtl/mult_div_iter.sv
// One combinational iteration of the magnitude datapath: shift-add multiply or
// restoring shift-subtract divide, selected by op_i.
module mult_div_iter
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_ITERS
) (
  input  op_e                  op_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opa_i,
  input  logic [WIDTH-1:0]     opb_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic [WIDTH-1:0]     opa_o,
  output logic [WIDTH-1:0]     opb_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;

  always_comb begin
    acc_o   = acc_i;
    opa_o   = opa_i;
    opb_o   = opb_i;
    addend  = '0;
    sum     = '0;
    partial = '0;
    diff    = '0;
    if (op_i == OP_MULT) begin
      // opa holds the multiplicand, opb the multiplier consumed LSB first
      addend = opb_i[0] ? opa_i : '0;
      sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      acc_o  = {sum, acc_i[WIDTH-1:1]};
      opb_o  = opb_i >> 1;
    end else begin
      // opa feeds dividend bits MSB first into the remainder; opb is the divisor
      partial = {acc_i[2*WIDTH-1:WIDTH], opa_i[WIDTH-1]};
      diff    = partial[WIDTH-1:0] - opb_i;
      opa_o   = opa_i << 1;
      if (partial >= {1'b0, opb_i}) begin
        acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {partial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multicycle MULT/DIV sequencer producing HI/LO with a single-cycle done strobe.
// Define MULTDIV_UNSIGNED_EN to add the is_unsigned input (MULTU/DIVU).
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hi_w,
  output logic             lo_w,
  output logic             div_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic                 dz_q, dz_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;

  logic [2*WIDTH-1:0]   acc_it;
  logic [WIDTH-1:0]     opa_it, opb_it;
  logic                 uns;
  logic                 sign_a, sign_b;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot, rem;

`ifdef MULTDIV_UNSIGNED_EN
  assign uns = is_unsigned;
`else
  assign uns = 1'b0;
`endif

  assign sign_a = ~uns & a[WIDTH-1];
  assign sign_b = ~uns & b[WIDTH-1];
  assign quot   = acc_q[WIDTH-1:0];
  assign rem    = acc_q[2*WIDTH-1:WIDTH];
  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;

  mult_div_iter #(.WIDTH(WIDTH)) u_iter (
    .op_i  (op_q),
    .acc_i (acc_q),
    .opa_i (opa_q),
    .opb_i (opb_q),
    .acc_o (acc_it),
    .opa_o (opa_it),
    .opb_o (opb_it)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_mult || start_div) begin
          // Multiply has priority when both starts arrive together
          op_d    = start_mult ? OP_MULT : OP_DIV;
          sa_d    = sign_a;
          sb_d    = sign_b;
          opa_d   = sign_a ? -a : a;
          opb_d   = sign_b ? -b : b;
          acc_d   = '0;
          cnt_d   = '0;
          dz_d    = ~start_mult & (b == '0);
          state_d = (~start_mult & (b == '0)) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_it;
        opa_d = opa_it;
        opb_d = opb_it;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (op_q == OP_MULT) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          // Quotient sign follows both operands; remainder follows the dividend
          lo_d = (sa_q ^ sb_q) ? -quot : quot;
          hi_d = sa_q ? -rem : rem;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Magnitude datapath is fully reloaded on every accepted start
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
    acc_q <= acc_d;
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign hi_w     = done & ~dz_q;
  assign lo_w     = done & ~dz_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
